// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write counters, RAW stall, writeback bypass,
// and a single registered operand slot toward execute (1-cycle issue latency).
module reg_file_scoreboard #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             rs1_en,
  input  logic             rs2_en,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [XLEN-1:0]  op_rs1_data,
  output logic [XLEN-1:0]  op_rs2_data,
  output logic             op_rd_en,
  output logic [AW-1:0]    op_rd,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             stall_hazard
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [CNT_W-1:0] PEND_ONE = CNT_W'(1);

  logic [XLEN-1:0]  regs [NREG];
  logic [CNT_W-1:0] pend [NREG];

  logic            byp1, byp2, haz1, haz2, sat;
  logic            slot_free, accept, inc_en, dec_en;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // A writeback retiring the last outstanding writer of a source clears the hazard.
  always_comb begin
    byp1 = rs1_en && (rs1 != '0) && wb_en && (wb_rd == rs1) && (pend[rs1] == PEND_ONE);
    byp2 = rs2_en && (rs2 != '0) && wb_en && (wb_rd == rs2) && (pend[rs2] == PEND_ONE);
    haz1 = rs1_en && (rs1 != '0) && (pend[rs1] != '0) && !byp1;
    haz2 = rs2_en && (rs2 != '0) && (pend[rs2] != '0) && !byp2;
    rs1_val = '0;
    if (rs1_en && (rs1 != '0)) rs1_val = byp1 ? wb_data : regs[rs1];
    rs2_val = '0;
    if (rs2_en && (rs2 != '0)) rs2_val = byp2 ? wb_data : regs[rs2];
    sat = rd_en && (rd != '0) && (pend[rd] == PEND_MAX) && !(wb_en && (wb_rd == rd));
  end

  assign slot_free    = !op_valid || op_ready;
  assign issue_ready  = !rst && slot_free && !haz1 && !haz2 && !sat;
  assign stall_hazard = issue_valid && slot_free && !issue_ready;
  assign accept       = issue_valid && issue_ready;
  assign inc_en       = accept && rd_en && (rd != '0);
  assign dec_en       = wb_en && (wb_rd != '0) && (pend[wb_rd] != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      op_valid    <= 1'b0;
      op_rs1_data <= '0;
      op_rs2_data <= '0;
      op_rd_en    <= 1'b0;
      op_rd       <= '0;
    end else begin
      if (wb_en && (wb_rd != '0)) regs[wb_rd] <= wb_data;
      // Increment and decrement on the same register cancel out.
      if (inc_en && !(dec_en && (wb_rd == rd))) pend[rd] <= pend[rd] + PEND_ONE;
      if (dec_en && !(inc_en && (wb_rd == rd))) pend[wb_rd] <= pend[wb_rd] - PEND_ONE;
      if (accept) begin
        op_valid    <= 1'b1;
        op_rs1_data <= rs1_val;
        op_rs2_data <= rs2_val;
        op_rd_en    <= rd_en;
        op_rd       <= rd;
      end else if (op_ready) begin
        op_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard bench: driver predicts accepts from an array/counter model and queues expected
// operands; a negedge monitor compares whatever the operand slot presents.
module tb_reg_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0, issue_ready;
  logic        rs1_en = 1'b0, rs2_en = 1'b0, rd_en = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        op_valid, op_ready = 1'b1;
  logic [31:0] op_rs1_data, op_rs2_data;
  logic        op_rd_en;
  logic [4:0]  op_rd;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        stall_hazard;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1_en(rs1_en), .rs2_en(rs2_en), .rs1(rs1), .rs2(rs2),
    .rd_en(rd_en), .rd(rd),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .op_rd_en(op_rd_en), .op_rd(op_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .stall_hazard(stall_hazard)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        de;
    logic [4:0]  d;
  } op_t;

  op_t         q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_regs [32];
  int          m_pend [32];
  bit          m_valid = 1'b0;
  localparam int MAXP = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare presented operands with the oldest expected issue.
  always @(negedge clk) begin
    if (op_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL op_unexpected actual=valid required=idle");
      end else begin
        chk("op_rs1_data", op_rs1_data, q[0].a);
        chk("op_rs2_data", op_rs2_data, q[0].b);
        chk("op_rd_en", {31'd0, op_rd_en}, {31'd0, q[0].de});
        chk("op_rd", {27'd0, op_rd}, {27'd0, q[0].d});
        if (op_ready) void'(q.pop_front());
      end
    end
  end

  task automatic src(input bit en, input logic [4:0] a, output bit haz, output logic [31:0] v);
    bit last_writer_retiring;
    haz = 1'b0;
    v   = 32'd0;
    if (en && a != 0) begin
      last_writer_retiring = wb_en && wb_rd == a && m_pend[a] == 1;
      haz = m_pend[a] > 0 && !last_writer_retiring;
      v   = last_writer_retiring ? wb_data : m_regs[a];
    end
  endtask

  // One clock: apply inputs, predict at mid-cycle, advance the model across the edge.
  task automatic cyc(input bit r, input bit iv,
                     input bit e1, input logic [4:0] a1, input bit e2, input logic [4:0] a2,
                     input bit de, input logic [4:0] d,
                     input bit we, input logic [4:0] wr, input logic [31:0] wd,
                     input bit ordy, input int exp_rdy);
    bit h1, h2, sat, free, rdy, acc;
    logic [31:0] v1, v2;
    rst = r; issue_valid = iv; rs1_en = e1; rs1 = a1; rs2_en = e2; rs2 = a2;
    rd_en = de; rd = d; wb_en = we; wb_rd = wr; wb_data = wd; op_ready = ordy;
    @(negedge clk);
    #1;
    chk("op_valid", {31'd0, op_valid}, {31'd0, m_valid});
    src(e1, a1, h1, v1);
    src(e2, a2, h2, v2);
    sat  = de && d != 0 && m_pend[d] == MAXP && !(we && wr == d);
    free = !m_valid || ordy;
    rdy  = !r && free && !h1 && !h2 && !sat;
    chk("issue_ready", {31'd0, issue_ready}, {31'd0, rdy});
    chk("stall_hazard", {31'd0, stall_hazard}, {31'd0, iv && free && !rdy});
    if (exp_rdy >= 0) chk("plan_ready", {31'd0, issue_ready}, exp_rdy);
    if (r) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_pend[i] = 0;
      end
      m_valid = 1'b0;
      q.delete();
    end else begin
      acc = iv && rdy;
      if (acc) q.push_back('{a: v1, b: v2, de: de, d: d});
      if (we && wr != 0) begin
        m_regs[wr] = wd;
        if (m_pend[wr] > 0) m_pend[wr]--;
      end
      if (acc && de && d != 0) m_pend[d]++;
      if (acc) m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit ordy);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, ordy, -1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 0;
    end
    // Reset; issue_ready must be low throughout.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
    chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
    chk("rst_op_rs1", op_rs1_data, 32'd0);
    chk("rst_op_rs2", op_rs2_data, 32'd0);
    chk("rst_op_rd", {26'd0, op_rd_en, op_rd}, 32'd0);

    // x0 reads zero and ignores writes.
    cyc(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'd0, 1, 1);
    chk("x0_issue_valid", {31'd0, op_valid}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, -1);
    cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'd0, 1, 1);
    chk("x0_read", op_rs1_data, 32'd0);

    // RAW on x5, resolved by same-cycle writeback bypass.
    cyc(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 32'd0, 1, 1);
    cyc(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
    cyc(0, 1, 1, 5, 0, 0, 0, 0, 1, 5, 32'h1234_5678, 1, 1);
    chk("bypass_x5", op_rs1_data, 32'h1234_5678);

    // Saturate x7, then a retiring writeback lets the fourth writer in.
    repeat (3) cyc(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'd0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'd0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0, 1, 7, 1, 7, 32'h0000_0077, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 32'd0, 1, 0);

    // WAW on x3: only the last writeback bypasses.
    cyc(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 32'd0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 32'd0, 1, 1);
    cyc(0, 1, 0, 0, 1, 3, 0, 0, 0, 0, 32'd0, 1, 0);
    cyc(0, 1, 0, 0, 1, 3, 0, 0, 1, 3, 32'h0000_000A, 1, 0);
    cyc(0, 1, 0, 0, 1, 3, 0, 0, 1, 3, 32'h0000_000B, 1, 1);
    chk("bypass_x3", op_rs2_data, 32'h0000_000B);

    // Backpressure: slot holds for 5 cycles, then refills in the release cycle.
    idle(1);
    cyc(0, 1, 1, 3, 1, 5, 1, 12, 0, 0, 32'd0, 0, 1);
    repeat (5) cyc(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
    chk("hold_rs1", op_rs1_data, 32'h0000_000B);
    cyc(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 32'd0, 1, 1);
    chk("release_rs1", op_rs1_data, 32'h1234_5678);

    // Reset mid-stall clears x9's pending writers.
    cyc(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 32'd0, 1, 1);
    cyc(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 32'd0, 1, 1);
    cyc(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
    cyc(1, 1, 1, 9, 0, 0, 0, 0, 0, 0, 32'd0, 1, 0);
    chk("rst_stall_op_valid", {31'd0, op_valid}, 32'd0);
    cyc(0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 32'd0, 1, 1);
    chk("post_rst_x9", op_rs1_data, 32'd0);

    // Random traffic over a few registers to keep hazards and saturation frequent.
    for (int n = 0; n < 3000; n++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
          $urandom_range(0, 1), 5'($urandom_range(0, 4)),
          $urandom_range(0, 1), 5'($urandom_range(0, 4)),
          $urandom_range(0, 1), 5'($urandom_range(0, 4)),
          ($urandom_range(0, 4) < 2), 5'($urandom_range(0, 4)), $urandom,
          ($urandom_range(0, 9) < 7), -1);
    end
    idle(1);
    idle(1);
    chk("drain", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
